// File: rtl/pbvi_step2_backup.sv
// pbvi_step2_backup: PBVI backup stage that consumes the step-1 gamma vectors.
// It takes a snapshot of gamma, belief and reward when start is sampled. It then
// scans one (observation, alpha) pair per cycle, in parallel for every action, and
// keeps the arg-max of the dot product with the belief. A final cycle adds the
// winning vectors to the reward.
// Build option: define PBVI_STEP2_SAT_EN to clamp the summed result at 2^W-1.
// Without it, the result wraps modulo 2^W.
module pbvi_step2_backup #(
  parameter int N_ACT   = 3,
  parameter int N_OBS   = 2,
  parameter int N_ALPHA = 16,
  parameter int N_ST    = 2,
  parameter int W       = 16,
  localparam int IW     = (N_ALPHA > 1) ? $clog2(N_ALPHA) : 1,
  localparam int OW     = (N_OBS > 1) ? $clog2(N_OBS) : 1
) (
  input  logic                                                     clk,
  input  logic                                                     rst_n,
  input  logic                                                     start,
  input  logic [N_ACT-1:0][N_OBS-1:0][N_ALPHA-1:0][N_ST-1:0][W-1:0] gamma_in,
  input  logic [N_ST-1:0][W-1:0]                                   belief,
  input  logic [N_ACT-1:0][N_ST-1:0][W-1:0]                        reward,
  output logic                                                     busy,
  output logic                                                     done,
  output logic [N_ACT-1:0][N_OBS-1:0][IW-1:0]                      best_idx,
  output logic [N_ACT-1:0][N_ST-1:0][W-1:0]                        gamma_ab
);

  // Full-precision dot product width: a W*W product plus carries from the N_ST terms.
  localparam int DW = 2 * W + ((N_ST > 1) ? $clog2(N_ST) : 1);

  // The saturating build needs the carries to detect overflow. The wrapping build
  // discards them anyway, so its accumulator is kept at W bits.
`ifdef PBVI_STEP2_SAT_EN
  localparam int SW = W + 2;
`else
  localparam int SW = W;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_SUM  = 2'd2
  } state_t;

  state_t                                                   state_q;
  logic [N_ACT-1:0][N_OBS-1:0][N_ALPHA-1:0][N_ST-1:0][W-1:0] gamma_q;
  logic [N_ST-1:0][W-1:0]                                   belief_q;
  logic [N_ACT-1:0][N_ST-1:0][W-1:0]                        reward_q;
  logic [OW-1:0]                                            o_q;
  logic [IW-1:0]                                            j_q;
  logic [N_ACT-1:0][N_OBS-1:0][DW-1:0]                      best_dot_q;
  logic [N_ACT-1:0][N_OBS-1:0][IW-1:0]                      best_idx_r_q;
  logic [N_ACT-1:0][N_OBS-1:0][IW-1:0]                      best_idx_q;
  logic [N_ACT-1:0][N_ST-1:0][W-1:0]                        gamma_ab_q;
  logic                                                     busy_q;
  logic                                                     done_q;

  logic [N_ACT-1:0][DW-1:0]                                 dot_d;
  logic [N_ACT-1:0][N_ST-1:0][SW-1:0]                       wide_d;
  logic [N_ACT-1:0][N_ST-1:0][W-1:0]                        gamma_ab_d;

  assign busy     = busy_q;
  assign done     = done_q;
  assign best_idx = best_idx_q;
  assign gamma_ab = gamma_ab_q;

  // Dot product of the gamma vector currently under scan with the belief, per action.
  always_comb begin
    dot_d = '0;
    for (int a = 0; a < N_ACT; a++) begin
      for (int s = 0; s < N_ST; s++) begin
        dot_d[a] = dot_d[a] + (DW'(gamma_q[a][o_q][j_q][s]) * DW'(belief_q[s]));
      end
    end
  end

  // Reward plus the winning gamma vector of every observation, per action and state.
  always_comb begin
    wide_d = '0;
    for (int a = 0; a < N_ACT; a++) begin
      for (int s = 0; s < N_ST; s++) begin
        wide_d[a][s] = SW'(reward_q[a][s]);
        for (int o = 0; o < N_OBS; o++) begin
          wide_d[a][s] = wide_d[a][s] + SW'(gamma_q[a][o][best_idx_r_q[a][o]][s]);
        end
      end
    end
  end

  // Reduce the summed result to W bits: clamp in the saturating build, wrap otherwise.
  always_comb begin
    gamma_ab_d = '0;
    for (int a = 0; a < N_ACT; a++) begin
      for (int s = 0; s < N_ST; s++) begin
`ifdef PBVI_STEP2_SAT_EN
        if (wide_d[a][s][SW-1:W] != '0) begin
          gamma_ab_d[a][s] = {W{1'b1}};
        end else begin
          gamma_ab_d[a][s] = wide_d[a][s][W-1:0];
        end
`else
        gamma_ab_d[a][s] = wide_d[a][s];
`endif
      end
    end
  end

  // Control FSM with snapshot capture, the arg-max scan and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      gamma_q      <= '0;
      belief_q     <= '0;
      reward_q     <= '0;
      o_q          <= '0;
      j_q          <= '0;
      best_dot_q   <= '0;
      best_idx_r_q <= '0;
      best_idx_q   <= '0;
      gamma_ab_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            gamma_q  <= gamma_in;
            belief_q <= belief;
            reward_q <= reward;
            o_q      <= '0;
            j_q      <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // Strict compare, so a tie keeps the lower index found earlier.
          for (int a = 0; a < N_ACT; a++) begin
            if ((j_q == '0) || (dot_d[a] > best_dot_q[a][o_q])) begin
              best_dot_q[a][o_q]   <= dot_d[a];
              best_idx_r_q[a][o_q] <= j_q;
            end
          end
          // N_ALPHA is a power of two, so j wraps to zero by itself.
          j_q <= j_q + IW'(1);
          if (j_q == IW'(N_ALPHA - 1)) begin
            if (o_q == OW'(N_OBS - 1)) begin
              o_q     <= '0;
              state_q <= ST_SUM;
            end else begin
              o_q <= o_q + OW'(1);
            end
          end
        end
        ST_SUM: begin
          gamma_ab_q <= gamma_ab_d;
          best_idx_q <= best_idx_r_q;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pbvi_step2_backup.sv
// Directed, table-driven bench for pbvi_step2_backup, plus hand-written sequences
// for the start-while-busy, mid-run reset and back-to-back start corner cases.
module tb_pbvi_step2_backup;

  localparam int NV = 5;

  typedef logic [2:0][1:0][15:0][1:0][15:0] gamma_t;
  typedef logic [1:0][15:0]                 bel_t;
  typedef logic [2:0][1:0][15:0]            rew_t;
  typedef logic [2:0][1:0][3:0]             idx_t;

  typedef struct packed {
    gamma_t g;
    bel_t   b;
    rew_t   r;
    idx_t   ei;
    rew_t   ea;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   start;
  gamma_t gamma_in;
  bel_t   belief;
  rew_t   reward;
  logic   busy;
  logic   done;
  idx_t   best_idx;
  rew_t   gamma_ab;

  vec_t vecs [NV];
  int   n_tests = 0;
  int   n_fail  = 0;

  pbvi_step2_backup dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .gamma_in (gamma_in),
    .belief   (belief),
    .reward   (reward),
    .busy     (busy),
    .done     (done),
    .best_idx (best_idx),
    .gamma_ab (gamma_ab)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int v);
    gamma_in = vecs[v].g;
    belief   = vecs[v].b;
    reward   = vecs[v].r;
  endtask

  // Called #1 after the edge that sampled start. Waits for done, optionally
  // injecting a start pulse with other data so that it is sampled at edge E10.
  task automatic wait_done(input string tag, input bit inject, input int inj_v, output int lat);
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      if (inject && c == 10) begin
        drive(inj_v);
        start = 1'b1;
      end
      if (inject && c == 11) start = 1'b0;
      @(posedge clk);
      #1;
      if (c == 1) chk({tag, " busy_scan"}, 128'(busy), 128'(1'b1));
      if (done) begin
        lat = c;
        break;
      end
    end
    chk({tag, " latency"}, 128'(lat), 128'(33));
  endtask

  task automatic check_result(input string tag, input int v);
    chk({tag, " best_idx"}, 128'(best_idx), 128'(vecs[v].ei));
    chk({tag, " gamma_ab"}, 128'(gamma_ab), 128'(vecs[v].ea));
    chk({tag, " busy_done"}, 128'(busy), 128'(1'b0));
  endtask

  task automatic run_vec(input string tag, input int v, input bit inject, input int inj_v);
    int lat;
    drive(v);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drive((v + 1) % NV);
    wait_done(tag, inject, inj_v, lat);
    check_result(tag, v);
    @(posedge clk);
    #1;
    chk({tag, " done_pulse"}, 128'(done), 128'(1'b0));
  endtask

  initial begin
    int lat;
    int dcount;
    for (int i = 0; i < NV; i++) vecs[i] = '0;

    // 0: single nonzero winner at index 5
    vecs[0].b = {16'h8000, 16'h8000};
    vecs[0].g[0][0][5] = {16'd100, 16'd100};
    vecs[0].ei[0][0] = 4'd5;
    vecs[0].ea[0] = {16'd100, 16'd100};

    // 1: all gamma equal -> ties resolve to index 0, result reward + 0x2468
    vecs[1].b = {16'h8000, 16'h8000};
    for (int a = 0; a < 3; a++)
      for (int o = 0; o < 2; o++)
        for (int j = 0; j < 16; j++)
          vecs[1].g[a][o][j] = {16'h1234, 16'h1234};
    vecs[1].r[0] = {16'h0101, 16'h0100};
    vecs[1].r[1] = {16'h0201, 16'h0200};
    vecs[1].r[2] = {16'h0301, 16'h0300};
    vecs[1].ea[0] = {16'h2569, 16'h2568};
    vecs[1].ea[1] = {16'h2669, 16'h2668};
    vecs[1].ea[2] = {16'h2769, 16'h2768};

    // 2: overflow of the SUM result on action 1 state 0
    vecs[2].b = {16'h8000, 16'h8000};
    for (int o = 0; o < 2; o++)
      for (int j = 0; j < 16; j++)
        vecs[2].g[1][o][j][0] = 16'h1000;
    vecs[2].r[1][0] = 16'hF000;
`ifdef PBVI_STEP2_SAT_EN
    vecs[2].ea[1][0] = 16'hFFFF;
`else
    vecs[2].ea[1][0] = 16'h1000;
`endif

    // 3: the late index 15 beats index 3 on the full-width dot product
    vecs[3].b = {16'h0000, 16'hFFFF};
    vecs[3].g[2][1][15] = {16'h0000, 16'hFFFF};
    vecs[3].g[2][1][3]  = {16'hFFFF, 16'hFFFE};
    vecs[3].r[2][1] = 16'h0001;
    vecs[3].ei[2][1] = 4'd15;
    vecs[3].ea[2] = {16'h0001, 16'hFFFF};

    // 4: different winners per observation, with a tie keeping index 9
    vecs[4].b = {16'hC000, 16'h4000};
    vecs[4].g[0][0][2]  = {16'h0300, 16'h0100};
    vecs[4].g[0][0][7]  = {16'h0100, 16'h0300};
    vecs[4].g[0][1][9]  = {16'h0010, 16'h0010};
    vecs[4].g[0][1][12] = {16'h0010, 16'h0010};
    vecs[4].g[1][0][0]  = {16'h0005, 16'h0005};
    vecs[4].g[1][1][14] = {16'h0000, 16'h0001};
    vecs[4].ei[0][0] = 4'd2;
    vecs[4].ei[0][1] = 4'd9;
    vecs[4].ei[1][1] = 4'd14;
    vecs[4].ea[0] = {16'h0310, 16'h0110};
    vecs[4].ea[1] = {16'h0005, 16'h0006};

    rst_n = 1'b0;
    start = 1'b0;
    drive(0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 128'(busy), 128'(1'b0));
    chk("reset done", 128'(done), 128'(1'b0));
    chk("reset best_idx", 128'(best_idx), 128'(0));
    chk("reset gamma_ab", 128'(gamma_ab), 128'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < NV; v++) run_vec($sformatf("vec%0d", v), v, 1'b0, 0);

    // A start pulse with other data sampled at E10 while busy is ignored.
    run_vec("ignore_start", 0, 1'b1, 4);

    // Reset asserted between E19 and E20 aborts the run with no done.
    run_vec("pre_reset", 3, 1'b0, 0);
    drive(1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset busy", 128'(busy), 128'(1'b0));
    chk("midreset done", 128'(done), 128'(1'b0));
    chk("midreset best_idx", 128'(best_idx), 128'(0));
    chk("midreset gamma_ab", 128'(gamma_ab), 128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    chk("midreset no_done", 128'(dcount), 128'(0));
    chk("midreset idle_busy", 128'(busy), 128'(1'b0));
    run_vec("after_reset", 1, 1'b0, 0);

    // A start in the same cycle as done begins a new run; outputs hold until the next SUM.
    drive(4);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("b2b_first", 1'b0, 0, lat);
    check_result("b2b_first", 4);
    drive(2);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drive(0);
    chk("b2b done_low", 128'(done), 128'(1'b0));
    chk("b2b hold gamma_ab", 128'(gamma_ab), 128'(vecs[4].ea));
    chk("b2b hold best_idx", 128'(best_idx), 128'(vecs[4].ei));
    wait_done("b2b_second", 1'b0, 0, lat);
    check_result("b2b_second", 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
